// File: rtl/fpu_bus_master_pkg.sv
// pa_fpu: shared constants and types for the FPU register bus.
// Holds the register map, the operation codes, the initiator state enum and a byte-select helper.
// No ports; imported by the bus master and its bench.
package pa_fpu;

   // Register map, little-endian within each multi-byte field.
   localparam logic [5:0] FPU_ADDR_A   = 6'h00;
   localparam logic [5:0] FPU_ADDR_B   = 6'h04;
   localparam logic [5:0] FPU_ADDR_OP  = 6'h08;
   localparam logic [5:0] FPU_ADDR_RES = 6'h10;

   // Operation codes understood by the FPU.
   localparam logic [7:0] op_add = 8'h00;
   localparam logic [7:0] op_sub = 8'h01;
   localparam logic [7:0] op_mul = 8'h02;
   localparam logic [7:0] op_div = 8'h03;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_STB,
      ST_WR_GAP,
      ST_WAIT_END,
      ST_RD_STB,
      ST_RD_GAP,
      ST_ACK,
      ST_DONE
   } e_fpu_master_st;

   // Byte idx of the write sequence: A[0..3], B[0..3], then the opcode.
   function automatic logic [7:0] fpu_wr_byte(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [7:0]  op,
                                              input logic [3:0]  idx);
      logic [31:0] w;
      w = idx[2] ? b : a;
      if (idx[3]) return op;
      return w[{idx[1:0], 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/fpu_bus_master.sv
// fpu_bus_master: writes A, B and opcode bytewise to the FPU, waits for cmd_end,
// reads the 32-bit result back bytewise, then handshakes end_ack and pulses done.
// Latency: 18 write cycles + cmd_end wait + 12 read cycles + ACK (>=1) + 1.
// Backpressure: start is accepted only while ready (idle and FPU not busy); otherwise dropped.
// Ports: clk/arst; start, op_a, op_b, opcode in; ready, done, error, result out;
//        fpu_* form the 8-bit FPU register bus (strobes active low).
module fpu_bus_master
   import pa_fpu::*;
#(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TO_W           = 13
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [7:0]  opcode,
   output logic        ready,
   output logic        done,
   output logic        error,
   output logic [31:0] result,
   output logic [7:0]  fpu_data_wr,
   input  logic [7:0]  fpu_data_rd,
   output logic [5:0]  fpu_addr,
   output logic        fpu_cs,
   output logic        fpu_rd,
   output logic        fpu_wr,
   output logic        fpu_end_ack,
   input  logic        fpu_cmd_end,
   input  logic        fpu_busy
);

   e_fpu_master_st state_q, state_d;
   logic [3:0]      idx_q, idx_d;
   logic [TO_W-1:0] to_q, to_d;
   logic            rd_ph_q, rd_ph_d;      // second cycle of a read strobe
   logic [31:0]     a_q, a_d, b_q, b_d;
   logic [7:0]      opc_q, opc_d;
   logic [31:0]     rbuf_q, rbuf_d;        // result bytes collected during reads
   logic [31:0]     result_q, result_d;
   logic            err_q, err_d;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         to_q     <= '0;
         rd_ph_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         opc_q    <= '0;
         rbuf_q   <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         to_q     <= to_d;
         rd_ph_q  <= rd_ph_d;
         a_q      <= a_d;
         b_q      <= b_d;
         opc_q    <= opc_d;
         rbuf_q   <= rbuf_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      to_d        = to_q;
      rd_ph_d     = rd_ph_q;
      a_d         = a_q;
      b_d         = b_q;
      opc_d       = opc_q;
      rbuf_d      = rbuf_q;
      result_d    = result_q;
      err_d       = err_q;
      fpu_cs      = 1'b1;
      fpu_rd      = 1'b1;
      fpu_wr      = 1'b1;
      fpu_end_ack = 1'b0;
      fpu_addr    = '0;
      fpu_data_wr = '0;
      done        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && !fpu_busy) begin
               a_d     = op_a;
               b_d     = op_b;
               opc_d   = opcode;
               idx_d   = '0;
               err_d   = 1'b0;
               state_d = ST_WR_STB;
            end
         end
         ST_WR_STB: begin
            fpu_cs      = 1'b0;
            fpu_wr      = 1'b0;
            fpu_addr    = FPU_ADDR_A + 6'(idx_q);
            fpu_data_wr = fpu_wr_byte(a_q, b_q, opc_q, idx_q);
            state_d     = ST_WR_GAP;
         end
         ST_WR_GAP: begin
            // Address and data stay stable through the recovery cycle.
            fpu_addr    = FPU_ADDR_A + 6'(idx_q);
            fpu_data_wr = fpu_wr_byte(a_q, b_q, opc_q, idx_q);
            if (idx_q == 4'd8) begin
               to_d    = '0;
               state_d = ST_WAIT_END;
            end else begin
               idx_d   = idx_q + 4'd1;
               state_d = ST_WR_STB;
            end
         end
         ST_WAIT_END: begin
            to_d = to_q + 1'b1;
            // cmd_end wins over a timeout expiring in the same cycle.
            if (fpu_cmd_end) begin
               idx_d   = '0;
               rd_ph_d = 1'b0;
               state_d = ST_RD_STB;
            end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_RD_STB: begin
            fpu_cs   = 1'b0;
            fpu_rd   = 1'b0;
            fpu_addr = FPU_ADDR_RES + {4'b0, idx_q[1:0]};
            if (!rd_ph_q) begin
               rd_ph_d = 1'b1;
            end else begin
               // Data is taken only after it has had a full strobe cycle to settle.
               rd_ph_d = 1'b0;
               rbuf_d[{idx_q[1:0], 3'b000} +: 8] = fpu_data_rd;
               state_d = ST_RD_GAP;
            end
         end
         ST_RD_GAP: begin
            fpu_addr = FPU_ADDR_RES + {4'b0, idx_q[1:0]};
            if (idx_q == 4'd3) begin
               state_d = ST_ACK;
            end else begin
               idx_d   = idx_q + 4'd1;
               state_d = ST_RD_STB;
            end
         end
         ST_ACK: begin
            fpu_end_ack = 1'b1;
            if (!fpu_cmd_end) begin
               result_d = rbuf_q;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign ready  = (state_q == ST_IDLE) && !fpu_busy;
   assign error  = (state_q == ST_DONE) && err_q;
   assign result = result_q;

endmodule

// File: tb/tb_fpu_bus_master.sv
// Bench for fpu_bus_master: behavioural FPU responder plus transaction-level scoreboard.
// Expected writes, read addresses, result, latency and end_ack length come from the register map and handshake rules.
// Random transactions are mixed with directed reset, busy, timeout and long cmd_end cases.
module tb_fpu_bus_master;
   import pa_fpu::*;

   localparam int TO_CYC = 64;

   logic        clk = 1'b0;
   logic        arst;
   logic        start;
   logic [31:0] op_a, op_b;
   logic [7:0]  opcode;
   logic        ready, done, error;
   logic [31:0] result;
   logic [7:0]  fpu_data_wr;
   logic [7:0]  fpu_data_rd = 8'h00;
   logic [5:0]  fpu_addr;
   logic        fpu_cs, fpu_rd, fpu_wr, fpu_end_ack;
   logic        fpu_cmd_end = 1'b0;
   logic        fpu_busy;

   fpu_bus_master #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(7)) dut (
      .clk(clk), .arst(arst), .start(start), .op_a(op_a), .op_b(op_b),
      .opcode(opcode), .ready(ready), .done(done), .error(error),
      .result(result), .fpu_data_wr(fpu_data_wr), .fpu_data_rd(fpu_data_rd),
      .fpu_addr(fpu_addr), .fpu_cs(fpu_cs), .fpu_rd(fpu_rd), .fpu_wr(fpu_wr),
      .fpu_end_ack(fpu_end_ack), .fpu_cmd_end(fpu_cmd_end), .fpu_busy(fpu_busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Responder parameters (written by the stimulus only).
   logic [31:0] resp_val = '0;
   int          resp_delay = 10;
   int          resp_hold = 0;
   bit          never_end = 1'b0;
   int          clr_req = 0;

   // Observations (written by the monitor only).
   int          clr_seen = 0;
   int          cyc = 0;
   logic [5:0]  wr_addr_q[$];
   logic [7:0]  wr_data_q[$];
   logic [5:0]  rd_addr_q[$];
   int          op_cyc = 0, done_cnt = 0, done_cyc = 0, ack_cnt = 0, cs_low_cnt = 0;
   int          viol = 0, end_cnt = -1, drop_cnt = 0, reads_done = 0, rd_len = 0;
   logic        done_err = 1'b0;
   logic [31:0] done_res = '0;
   bit          prev_wr = 1'b0, prev_rd = 1'b0, cur_wr, cur_rd;

   function automatic logic [7:0] res_byte(input logic [31:0] v, input logic [5:0] a);
      int k;
      k = int'(a) - 16;
      if (k < 0 || k > 3) return 8'hEE;
      return 8'((v >> (8 * k)) & 32'hFF);
   endfunction

   // Monitor + behavioural FPU, acting on the falling edge.
   initial forever begin
      @(negedge clk);
      cyc++;
      if (clr_req != clr_seen) begin
         clr_seen = clr_req;
         wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
         done_cnt = 0; ack_cnt = 0; cs_low_cnt = 0; reads_done = 0;
         end_cnt = -1; drop_cnt = 0;
      end
      if (arst) begin
         prev_wr = 1'b0; prev_rd = 1'b0; rd_len = 0;
         end_cnt = -1; drop_cnt = 0; fpu_cmd_end = 1'b0;
      end else begin
         if (end_cnt > 0) begin
            end_cnt--;
            if (end_cnt == 0) begin
               fpu_cmd_end = 1'b1;
               end_cnt = -1;
            end
         end
         if (drop_cnt > 0) begin
            drop_cnt--;
            if (drop_cnt == 0) fpu_cmd_end = 1'b0;
         end
         cur_wr = !fpu_cs && !fpu_wr;
         cur_rd = !fpu_cs && !fpu_rd;
         if (!fpu_cs) cs_low_cnt++;
         if (!fpu_cs && (fpu_rd == fpu_wr)) viol++;
         if (cur_wr && (prev_wr || prev_rd)) viol++;
         if (cur_rd && prev_wr) viol++;
         if (cur_wr) begin
            wr_addr_q.push_back(fpu_addr);
            wr_data_q.push_back(fpu_data_wr);
            if (fpu_addr == FPU_ADDR_OP) begin
               op_cyc = cyc;
               if (!never_end) end_cnt = resp_delay;
            end
         end
         if (cur_rd) begin
            rd_len++;
            if (!prev_rd) begin
               rd_addr_q.push_back(fpu_addr);
               fpu_data_rd = res_byte(resp_val, fpu_addr);
            end
         end else if (prev_rd) begin
            if (rd_len != 2) viol++;
            rd_len = 0;
            reads_done++;
            if (reads_done == 4) begin
               if (resp_hold == 0) fpu_cmd_end = 1'b0;
               else drop_cnt = resp_hold;
            end
         end
         if (fpu_end_ack) ack_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = error;
            done_res = result;
         end
         prev_wr = cur_wr;
         prev_rd = cur_rd;
      end
   end

   logic [31:0] exp_last_res = '0;

   task automatic reset_resp();
      clr_req++;
      @(negedge clk); #1;
   endtask

   task automatic start_txn(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (ready) begin ok = 1'b1; break; end
      end
      check("ready_wait", 64'(ok), 64'd1);
      op_a = a; op_b = b; opcode = op; start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      // Scramble inputs: the master must use its latched copies.
      op_a = $urandom; op_b = $urandom; opcode = 8'($urandom);
   endtask

   task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op,
                          input logic [31:0] rv, input int d, input int h, input bit to);
      bit got_done = 1'b0;
      int hmin;
      logic [7:0] eb;
      resp_val = rv; resp_delay = d; resp_hold = h; never_end = to;
      reset_resp();
      start_txn(a, b, op);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk); #1;
         if (done_cnt != 0) begin got_done = 1'b1; break; end
      end
      check("done_seen", 64'(got_done), 64'd1);
      repeat (3) @(negedge clk);
      #1;
      check("done_pulses", 64'(done_cnt), 64'd1);
      check("wr_count", 64'(wr_addr_q.size()), 64'd9);
      for (int i = 0; i < 9 && i < wr_addr_q.size(); i++) begin
         if (i < 4) eb = 8'((a >> (8 * i)) & 32'hFF);
         else if (i < 8) eb = 8'((b >> (8 * (i - 4))) & 32'hFF);
         else eb = op;
         check($sformatf("wr_addr%0d", i), 64'(wr_addr_q[i]), 64'(i));
         check($sformatf("wr_data%0d", i), 64'(wr_data_q[i]), 64'(eb));
      end
      if (!to) begin
         hmin = (h > 1) ? h : 1;
         check("rd_count", 64'(rd_addr_q.size()), 64'd4);
         for (int i = 0; i < 4 && i < rd_addr_q.size(); i++)
            check($sformatf("rd_addr%0d", i), 64'(rd_addr_q[i]), 64'(16 + i));
         check("error", 64'(done_err), 64'd0);
         check("result", 64'(done_res), 64'(rv));
         check("latency", 64'(done_cyc - op_cyc), 64'(d + 13 + hmin));
         check("ack_cycles", 64'(ack_cnt), 64'(hmin));
         exp_last_res = rv;
      end else begin
         check("to_rd_count", 64'(rd_addr_q.size()), 64'd0);
         check("to_ack_cycles", 64'(ack_cnt), 64'd0);
         check("to_error", 64'(done_err), 64'd1);
         check("to_result", 64'(done_res), 64'(exp_last_res));
         check("to_latency", 64'(done_cyc - op_cyc), 64'(2 + TO_CYC));
      end
   endtask

   task automatic mid_reset(input int byte_n);
      bit hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (!fpu_cs && !fpu_wr && fpu_addr == 6'(byte_n)) begin hit = 1'b1; break; end
      end
      check("mid_strobe_found", 64'(hit), 64'd1);
      arst = 1'b1;
      #1;
      check("arst_strobes", 64'({fpu_cs, fpu_rd, fpu_wr}), 64'b111);
      repeat (3) @(negedge clk);
      #1;
      check("arst_outputs", 64'({fpu_end_ack, done, error}), 64'd0);
      check("arst_result", 64'(result), 64'd0);
      check("arst_addr", 64'(fpu_addr), 64'd0);
      arst = 1'b0;
      exp_last_res = '0;
      repeat (4) @(negedge clk);
      #1;
      check("post_arst_ready", 64'(ready), 64'd1);
      check("post_arst_no_done", 64'(done_cnt), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      arst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; opcode = '0; fpu_busy = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_strobes", 64'({fpu_cs, fpu_rd, fpu_wr}), 64'b111);
      arst = 1'b0;

      // 1: reset in the middle of a sequence.
      reset_resp();
      start_txn(32'h1234_5678, 32'h9ABC_DEF0, op_mul);
      mid_reset(5);

      // 2: directed add.
      run_txn(32'h4080_0000, 32'h4180_0000, op_add, 32'h41A0_0000, 10, 0, 1'b0);

      // 3: start while the FPU is busy is dropped.
      reset_resp();
      fpu_busy = 1'b1;
      @(negedge clk); #1;
      check("busy_ready", 64'(ready), 64'd0);
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      check("busy_no_cs", 64'(cs_low_cnt), 64'd0);
      fpu_busy = 1'b0;
      run_txn(32'h3F80_0000, 32'hBF80_0000, op_sub, 32'h0000_0000, 5, 1, 1'b0);

      // 5: cmd_end held past the last read.
      run_txn(32'hDEAD_BEEF, 32'h0BAD_F00D, op_div, 32'hC0FF_EE11, 7, 3, 1'b0);

      // 4: no cmd_end at all.
      run_txn(32'h1111_2222, 32'h3333_4444, op_add, 32'h5555_6666, 0, 0, 1'b1);

      // 6: reset during byte 3, then a clean rerun.
      reset_resp();
      start_txn(32'hA5A5_5A5A, 32'h0F0F_F0F0, op_mul);
      mid_reset(3);
      run_txn(32'hA5A5_5A5A, 32'h0F0F_F0F0, op_mul, 32'h7F7F_0101, 12, 0, 1'b0);

      // Random transactions.
      for (int n = 0; n < 6; n++) begin
         run_txn($urandom, $urandom, 8'($urandom_range(0, 3)), $urandom,
                 int'($urandom_range(2, 40)), int'($urandom_range(0, 4)), 1'b0);
      end

      check("protocol_viol", 64'(viol), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
